// File: rtl/branch_resolve_if.sv
// Request/response bundle between the execute stage and the branch resolve unit.
// The execute side uses the master modport; the resolve unit uses slave.
interface branch_resolve_if #(parameter int XLEN = 32);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic            rvc;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] old_pc;
   logic [XLEN-1:0] pred_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] dst;
   logic            dst_we;
   logic [XLEN-1:0] new_pc;
   logic            taken;
   logic            mispredict;
   logic            exception;
   logic [XLEN-1:0] ras_top;
   logic            ras_valid;

   modport master (
      output flush, in_valid, opcode, funct3, rd, rs1, rvc, src1, src2, imm, old_pc, pred_pc,
             out_ready,
      input  in_ready, out_valid, dst, dst_we, new_pc, taken, mispredict, exception,
             ras_top, ras_valid
   );

   modport slave (
      input  flush, in_valid, opcode, funct3, rd, rs1, rvc, src1, src2, imm, old_pc, pred_pc,
             out_ready,
      output in_ready, out_valid, dst, dst_we, new_pc, taken, mispredict, exception,
             ras_top, ras_valid
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered control-flow resolver (LUI/AUIPC/JAL/JALR/Bxx) with a valid/ready
// output stage and a return-address stack feeding fetch-side return prediction.
module branch_resolve_unit #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 8,
   parameter int C_EXT     = 0
) (
   input logic             clk,
   input logic             reset,
   branch_resolve_if.slave bus
);
   localparam int PW = $clog2(RAS_DEPTH);

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   typedef struct packed {
      logic [XLEN-1:0] dst;
      logic            dst_we;
      logic [XLEN-1:0] new_pc;
      logic            taken;
      logic            mispredict;
      logic            exception;
   } res_t;

   res_t            dec, res_d, res_q;
   logic            out_valid_d, out_valid_q;
   logic [XLEN-1:0] ras_mem_d [RAS_DEPTH];
   logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
   logic [PW-1:0]   ptr_d, ptr_q;
   logic [PW:0]     cnt_d, cnt_q;

   logic            in_ready, accept;
   logic [XLEN-1:0] seq, tgt;
   logic            take, illegal, misal, is_jal, is_jalr;
   logic            l_rd, l_rs1, push, pop;

   assign in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   // Instruction decode and target resolution
   always_comb begin
      seq     = bus.old_pc + ((C_EXT != 0 && bus.rvc) ? XLEN'(2) : XLEN'(4));
      tgt     = seq;
      take    = 1'b0;
      illegal = 1'b0;
      is_jal  = 1'b0;
      is_jalr = 1'b0;
      dec     = '0;
      case (bus.opcode)
         OP_LUI: begin
            dec.dst    = bus.imm;
            dec.dst_we = 1'b1;
         end
         OP_AUIPC: begin
            dec.dst    = bus.old_pc + bus.imm;
            dec.dst_we = 1'b1;
         end
         OP_JAL: begin
            dec.dst    = seq;
            dec.dst_we = 1'b1;
            take       = 1'b1;
            tgt        = bus.old_pc + bus.imm;
            is_jal     = 1'b1;
         end
         OP_JALR: begin
            dec.dst    = seq;
            dec.dst_we = 1'b1;
            take       = 1'b1;
            tgt        = (bus.src1 + bus.imm) & ~XLEN'(1);
            illegal    = (bus.funct3 != 3'b000);
            is_jalr    = 1'b1;
         end
         OP_BR: begin
            case (bus.funct3)
               3'b000:  take = (bus.src1 == bus.src2);
               3'b001:  take = (bus.src1 != bus.src2);
               3'b100:  take = ($signed(bus.src1) <  $signed(bus.src2));
               3'b101:  take = ($signed(bus.src1) >= $signed(bus.src2));
               3'b110:  take = (bus.src1 <  bus.src2);
               3'b111:  take = (bus.src1 >= bus.src2);
               default: illegal = 1'b1;
            endcase
            if (take) tgt = bus.old_pc + bus.imm;
         end
         default: ;
      endcase
      // Only a redirect that is actually taken can fault on alignment
      misal         = (C_EXT != 0) ? tgt[0] : (tgt[1:0] != 2'b00);
      dec.exception = illegal || (take && misal);
      if (dec.exception) begin
         dec.dst    = '0;
         dec.dst_we = 1'b0;
         dec.new_pc = bus.old_pc;
      end else begin
         dec.new_pc     = tgt;
         dec.taken      = take;
         dec.mispredict = (tgt != bus.pred_pc);
      end
   end

   // Return-address stack: pop (if any) is applied before push, so a
   // pop+push on a non-empty stack replaces the top in place.
   always_comb begin
      l_rd  = (bus.rd == 5'd1) || (bus.rd == 5'd5);
      l_rs1 = (bus.rs1 == 5'd1) || (bus.rs1 == 5'd5);
      push  = 1'b0;
      pop   = 1'b0;
      if (accept && !dec.exception) begin
         push = (is_jal || is_jalr) && l_rd;
         pop  = is_jalr && l_rs1 && !(l_rd && bus.rd == bus.rs1);
      end
      ras_mem_d = ras_mem_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      if (pop && cnt_q != '0) begin
         ptr_d = ptr_q - PW'(1);
         cnt_d = cnt_q - (PW+1)'(1);
      end
      if (push) begin
         ras_mem_d[ptr_d] = seq;
         ptr_d            = ptr_d + PW'(1);
         if (cnt_d != (PW+1)'(RAS_DEPTH)) cnt_d = cnt_d + (PW+1)'(1);
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      res_d       = res_q;
      if (accept) begin
         out_valid_d = 1'b1;
         res_d       = dec;
      end else if (bus.flush || bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         ras_mem_q   <= ras_mem_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.dst        = res_q.dst;
   assign bus.dst_we     = res_q.dst_we;
   assign bus.new_pc     = res_q.new_pc;
   assign bus.taken      = res_q.taken;
   assign bus.mispredict = res_q.mispredict;
   assign bus.exception  = res_q.exception;
   assign bus.ras_top    = ras_mem_q[ptr_q - PW'(1)];
   assign bus.ras_valid  = (cnt_q != '0);
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, call/return and
// handshake sequences, and randomized traffic against a queue-based RAS model.
module tb_branch_resolve_unit;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic        rvc;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] imm;
      logic [31:0] old_pc;
      logic [31:0] pred_pc;
   } req_t;

   typedef struct packed {
      logic [31:0] dst;
      logic        dst_we;
      logic [31:0] new_pc;
      logic        taken;
      logic        mispredict;
      logic        exception;
   } exp_t;

   typedef struct {
      req_t r;
      exp_t e;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_pass = 0;
   int   n_tot  = 0;
   logic [31:0] ras_q[$];

   branch_resolve_if #(.XLEN(32)) bif0 ();
   branch_resolve_if #(.XLEN(32)) bif1 ();

   branch_resolve_unit #(.XLEN(32), .RAS_DEPTH(8), .C_EXT(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bif0));
   branch_resolve_unit #(.XLEN(32), .RAS_DEPTH(8), .C_EXT(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bif1));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
   endtask

   function automatic req_t mk(input logic [6:0] op, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [31:0] s1, input logic [31:0] s2,
                               input logic [31:0] imm, input logic [31:0] old,
                               input logic [31:0] pred);
      req_t r;
      r = '{opcode: op, funct3: f3, rd: rd, rs1: rs1, rvc: 1'b0, src1: s1, src2: s2,
            imm: imm, old_pc: old, pred_pc: pred};
      return r;
   endfunction

   function automatic exp_t mke(input logic [31:0] dst, input logic we, input logic [31:0] npc,
                                input logic tk, input logic mp, input logic ex);
      exp_t e;
      e = '{dst: dst, dst_we: we, new_pc: npc, taken: tk, mispredict: mp, exception: ex};
      return e;
   endfunction

   // Reference: the architectural outcome of one instruction
   function automatic exp_t ref_out(input req_t r, input bit c);
      exp_t        e;
      logic [31:0] seq, tgt;
      bit          tk, ex;
      e   = '0;
      tk  = 0;
      ex  = 0;
      seq = r.old_pc + ((c && r.rvc) ? 32'd2 : 32'd4);
      tgt = seq;
      case (r.opcode)
         OP_LUI:   begin e.dst = r.imm; e.dst_we = 1; end
         OP_AUIPC: begin e.dst = r.old_pc + r.imm; e.dst_we = 1; end
         OP_JAL:   begin e.dst = seq; e.dst_we = 1; tk = 1; tgt = r.old_pc + r.imm; end
         OP_JALR: begin
            e.dst = seq; e.dst_we = 1; tk = 1;
            tgt = (r.src1 + r.imm) & 32'hFFFF_FFFE;
            ex  = (r.funct3 != 0);
         end
         OP_BR: begin
            case (r.funct3)
               3'd0: tk = (r.src1 == r.src2);
               3'd1: tk = (r.src1 != r.src2);
               3'd4: tk = ($signed(r.src1) < $signed(r.src2));
               3'd5: tk = !($signed(r.src1) < $signed(r.src2));
               3'd6: tk = (r.src1 < r.src2);
               3'd7: tk = !(r.src1 < r.src2);
               default: ex = 1;
            endcase
            if (tk) tgt = r.old_pc + r.imm;
         end
         default: ;
      endcase
      if (tk && ((c ? (tgt % 2) : (tgt % 4)) != 0)) ex = 1;
      if (ex) e = mke(32'h0, 1'b0, r.old_pc, 1'b0, 1'b0, 1'b1);
      else begin
         e.new_pc     = tgt;
         e.taken      = tk;
         e.mispredict = (tgt != r.pred_pc);
      end
      return e;
   endfunction

   // Reference RAS: a bounded stack where overflow discards the oldest entry
   task automatic ref_ras(input req_t r);
      exp_t e;
      bit   lrd, lrs, psh, pp;
      e   = ref_out(r, 1'b0);
      lrd = (r.rd == 5'd1 || r.rd == 5'd5);
      lrs = (r.rs1 == 5'd1 || r.rs1 == 5'd5);
      psh = 0;
      pp  = 0;
      if (!e.exception) begin
         if (r.opcode == OP_JAL) psh = lrd;
         else if (r.opcode == OP_JALR) begin
            case ({lrd, lrs})
               2'b10:   psh = 1;
               2'b01:   pp = 1;
               2'b11:   begin psh = 1; pp = (r.rd != r.rs1); end
               default: ;
            endcase
         end
      end
      if (pp && ras_q.size() > 0) void'(ras_q.pop_back());
      if (psh) begin
         ras_q.push_back(r.old_pc + 32'd4);
         if (ras_q.size() > 8) void'(ras_q.pop_front());
      end
   endtask

   task automatic put0(input req_t r);
      bif0.opcode = r.opcode; bif0.funct3 = r.funct3; bif0.rd = r.rd; bif0.rs1 = r.rs1;
      bif0.rvc = r.rvc; bif0.src1 = r.src1; bif0.src2 = r.src2; bif0.imm = r.imm;
      bif0.old_pc = r.old_pc; bif0.pred_pc = r.pred_pc;
   endtask

   task automatic put1(input req_t r);
      bif1.opcode = r.opcode; bif1.funct3 = r.funct3; bif1.rd = r.rd; bif1.rs1 = r.rs1;
      bif1.rvc = r.rvc; bif1.src1 = r.src1; bif1.src2 = r.src2; bif1.imm = r.imm;
      bif1.old_pc = r.old_pc; bif1.pred_pc = r.pred_pc;
   endtask

   task automatic send0(input req_t r);
      bit ok;
      ok = 0;
      for (int i = 0; i < 8; i++) begin
         if (bif0.in_ready === 1'b1) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk("send.in_ready", {31'h0, ok}, 32'h1);
      put0(r);
      bif0.in_valid = 1'b1;
      @(posedge clk); #1;
      bif0.in_valid = 1'b0;
      if (ok) ref_ras(r);
   endtask

   task automatic chk_out(input string nm, input exp_t e);
      chk({nm, ".out_valid"}, {31'h0, bif0.out_valid}, 32'h1);
      chk({nm, ".dst"}, bif0.dst, e.dst);
      chk({nm, ".dst_we"}, {31'h0, bif0.dst_we}, {31'h0, e.dst_we});
      chk({nm, ".new_pc"}, bif0.new_pc, e.new_pc);
      chk({nm, ".taken"}, {31'h0, bif0.taken}, {31'h0, e.taken});
      chk({nm, ".mispredict"}, {31'h0, bif0.mispredict}, {31'h0, e.mispredict});
      chk({nm, ".exception"}, {31'h0, bif0.exception}, {31'h0, e.exception});
   endtask

   task automatic chk_ras(input string nm);
      chk({nm, ".ras_valid"}, {31'h0, bif0.ras_valid}, (ras_q.size() != 0) ? 32'h1 : 32'h0);
      if (ras_q.size() != 0) chk({nm, ".ras_top"}, bif0.ras_top, ras_q[$]);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      ras_q.delete();
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 4))
         0:       return 5'd0;
         1:       return 5'd1;
         2:       return 5'd5;
         3:       return 5'd2;
         default: return 5'($urandom);
      endcase
   endfunction

   initial begin
      vec_t vt[18];
      req_t r, a, b;
      exp_t e;

      vt[0]  = '{mk(OP_BR, 3'd0, 0, 0, 32'd5, 32'd5, 32'h20, 32'h100, 32'h104), mke(0, 0, 32'h120, 1, 1, 0)};
      vt[1]  = '{mk(OP_BR, 3'd0, 0, 0, 32'd5, 32'd6, 32'h20, 32'h100, 32'h104), mke(0, 0, 32'h104, 0, 0, 0)};
      vt[2]  = '{mk(OP_BR, 3'd1, 0, 0, 32'd1, 32'd2, 32'h10, 32'h300, 32'h310), mke(0, 0, 32'h310, 1, 0, 0)};
      vt[3]  = '{mk(OP_BR, 3'd4, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h400, 32'h404), mke(0, 0, 32'h408, 1, 1, 0)};
      vt[4]  = '{mk(OP_BR, 3'd6, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h400, 32'h404), mke(0, 0, 32'h404, 0, 0, 0)};
      vt[5]  = '{mk(OP_BR, 3'd5, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h400, 32'h3F8), mke(0, 0, 32'h3F8, 1, 0, 0)};
      vt[6]  = '{mk(OP_BR, 3'd7, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'h8, 32'h400, 32'h0), mke(0, 0, 32'h404, 0, 1, 0)};
      vt[7]  = '{mk(OP_LUI, 3'd0, 3, 0, 0, 0, 32'h1234_5000, 32'h500, 32'h504), mke(32'h1234_5000, 1, 32'h504, 0, 0, 0)};
      vt[8]  = '{mk(OP_AUIPC, 3'd0, 3, 0, 0, 0, 32'h1000, 32'h500, 32'h600), mke(32'h1500, 1, 32'h504, 0, 1, 0)};
      vt[9]  = '{mk(OP_BR, 3'd2, 0, 0, 0, 0, 32'h20, 32'h600, 32'h604), mke(0, 0, 32'h600, 0, 0, 1)};
      vt[10] = '{mk(OP_BR, 3'd3, 0, 0, 0, 0, 32'h20, 32'h610, 32'h614), mke(0, 0, 32'h610, 0, 0, 1)};
      vt[11] = '{mk(OP_JALR, 3'd1, 2, 3, 32'h1000, 0, 0, 32'h620, 32'h1000), mke(0, 0, 32'h620, 0, 0, 1)};
      vt[12] = '{mk(OP_JAL, 3'd0, 1, 0, 0, 0, 32'h2, 32'h700, 32'h702), mke(0, 0, 32'h700, 0, 0, 1)};
      vt[13] = '{mk(OP_BR, 3'd0, 0, 0, 32'd7, 32'd7, 32'h6, 32'h100, 32'h106), mke(0, 0, 32'h100, 0, 0, 1)};
      vt[14] = '{mk(OP_BR, 3'd1, 0, 0, 32'd7, 32'd7, 32'h6, 32'h100, 32'h104), mke(0, 0, 32'h104, 0, 0, 0)};
      vt[15] = '{mk(OP_LOAD, 3'd2, 4, 2, 32'h55, 0, 32'h44, 32'h800, 32'h804), mke(0, 0, 32'h804, 0, 0, 0)};
      vt[16] = '{mk(OP_JALR, 3'd0, 2, 3, 32'h901, 0, 32'h10, 32'h900, 32'h910), mke(32'h904, 1, 32'h910, 1, 0, 0)};
      vt[17] = '{mk(OP_JALR, 3'd0, 0, 3, 32'h902, 0, 0, 32'h900, 32'h0), mke(0, 0, 32'h900, 0, 0, 1)};

      bif0.flush = 0; bif0.in_valid = 0; bif0.out_ready = 1; put0('0);
      bif1.flush = 0; bif1.in_valid = 0; bif1.out_ready = 1; put1('0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      chk("rst.out_valid", {31'h0, bif0.out_valid}, 32'h0);
      chk("rst.new_pc", bif0.new_pc, 32'h0);
      chk("rst.dst", bif0.dst, 32'h0);
      chk("rst.ras_valid", {31'h0, bif0.ras_valid}, 32'h0);
      chk("rst.ras_top", bif0.ras_top, 32'h0);
      chk("rst.in_ready", {31'h0, bif0.in_ready}, 32'h1);

      foreach (vt[i]) begin
         send0(vt[i].r);
         chk_out($sformatf("vec%0d", i), vt[i].e);
         chk_ras($sformatf("vec%0d", i));
      end

      // Call / return, including replace-on-one-deep-stack
      do_reset();
      send0(mk(OP_JAL, 0, 1, 0, 0, 0, 32'h40, 32'h200, 32'h240));
      chk("call.dst", bif0.dst, 32'h204);
      chk("call.new_pc", bif0.new_pc, 32'h240);
      chk("call.ras_top", bif0.ras_top, 32'h204);
      chk("call.ras_valid", {31'h0, bif0.ras_valid}, 32'h1);
      send0(mk(OP_JALR, 0, 0, 1, 32'h204, 0, 0, 32'h240, 32'h204));
      chk("ret.new_pc", bif0.new_pc, 32'h204);
      chk("ret.ras_valid", {31'h0, bif0.ras_valid}, 32'h0);
      send0(mk(OP_JAL, 0, 1, 0, 0, 0, 32'h40, 32'h200, 32'h240));
      send0(mk(OP_JALR, 0, 1, 5, 32'h800, 0, 0, 32'h300, 32'h800));
      chk("repl.dst", bif0.dst, 32'h304);
      chk("repl.ras_top", bif0.ras_top, 32'h304);
      chk("repl.ras_valid", {31'h0, bif0.ras_valid}, 32'h1);
      send0(mk(OP_JALR, 0, 0, 1, 32'h304, 0, 0, 32'h800, 32'h304));
      chk("repl.count1", {31'h0, bif0.ras_valid}, 32'h0);

      // Overflow: nine calls into an eight-deep stack, then drain
      do_reset();
      for (int k = 0; k < 9; k++)
         send0(mk(OP_JAL, 0, 1, 0, 0, 0, 32'h100, 32'h1000 + 32'h10 * k, 32'h0));
      chk("ovf.top", bif0.ras_top, 32'h1084);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ovf.pop%0d", i), bif0.ras_top, 32'h1084 - 32'h10 * i);
         send0(mk(OP_JALR, 0, 0, 1, 32'h2000, 0, 0, 32'h3000, 32'h2000));
      end
      chk("ovf.empty", {31'h0, bif0.ras_valid}, 32'h0);
      send0(mk(OP_JALR, 0, 0, 1, 32'h2000, 0, 0, 32'h3000, 32'h2000));
      chk("ovf.pop_empty", {31'h0, bif0.ras_valid}, 32'h0);
      chk_ras("ovf.model");

      // RVC alignment on the C_EXT instance
      r = mk(OP_JAL, 0, 1, 0, 0, 0, 32'h2, 32'h700, 32'h702);
      r.rvc = 1'b1;
      put1(r); bif1.in_valid = 1'b1; @(posedge clk); #1; bif1.in_valid = 1'b0;
      chk("rvc.exception", {31'h0, bif1.exception}, 32'h0);
      chk("rvc.dst", bif1.dst, 32'h702);
      chk("rvc.new_pc", bif1.new_pc, 32'h702);
      chk("rvc.ras_top", bif1.ras_top, 32'h702);
      r = mk(OP_JAL, 0, 1, 0, 0, 0, 32'h1, 32'h800, 32'h801);
      r.rvc = 1'b1;
      put1(r); bif1.in_valid = 1'b1; @(posedge clk); #1; bif1.in_valid = 1'b0;
      chk("rvc_odd.exception", {31'h0, bif1.exception}, 32'h1);
      chk("rvc_odd.new_pc", bif1.new_pc, 32'h800);
      chk("rvc_odd.ras_top", bif1.ras_top, 32'h702);

      // Backpressure, consume+accept, flush, reset mid-stream
      do_reset();
      bif0.out_ready = 1'b0;
      a = mk(OP_JAL, 0, 1, 0, 0, 0, 32'h40, 32'h200, 32'h240);
      send0(a);
      b = mk(OP_LUI, 0, 3, 0, 0, 0, 32'h5000, 32'h300, 32'h304);
      put0(b); bif0.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stall%0d.in_ready", i), {31'h0, bif0.in_ready}, 32'h0);
         @(posedge clk); #1;
         chk($sformatf("stall%0d.new_pc", i), bif0.new_pc, 32'h240);
         chk($sformatf("stall%0d.dst", i), bif0.dst, 32'h204);
         chk($sformatf("stall%0d.out_valid", i), {31'h0, bif0.out_valid}, 32'h1);
      end
      bif0.out_ready = 1'b1;
      #1 chk("cons.in_ready", {31'h0, bif0.in_ready}, 32'h1);
      @(posedge clk); #1;
      bif0.in_valid = 1'b0;
      ref_ras(b);
      chk_out("cons_acc", ref_out(b, 1'b0));
      @(posedge clk); #1;
      chk("drain.out_valid", {31'h0, bif0.out_valid}, 32'h0);
      chk_ras("drain");

      send0(mk(OP_JAL, 0, 5, 0, 0, 0, 32'h8, 32'h400, 32'h408));
      put0(b); bif0.in_valid = 1'b1; bif0.flush = 1'b1;
      #1 chk("flush.in_ready", {31'h0, bif0.in_ready}, 32'h0);
      @(posedge clk); #1;
      bif0.in_valid = 1'b0; bif0.flush = 1'b0;
      chk("flush.out_valid", {31'h0, bif0.out_valid}, 32'h0);
      chk("flush.ras_top", bif0.ras_top, 32'h404);
      chk_ras("flush");

      send0(mk(OP_JAL, 0, 1, 0, 0, 0, 32'h40, 32'h600, 32'h0));
      do_reset();
      chk("mrst.out_valid", {31'h0, bif0.out_valid}, 32'h0);
      chk("mrst.dst", bif0.dst, 32'h0);
      chk("mrst.dst_we", {31'h0, bif0.dst_we}, 32'h0);
      chk("mrst.new_pc", bif0.new_pc, 32'h0);
      chk("mrst.taken", {31'h0, bif0.taken}, 32'h0);
      chk("mrst.mispredict", {31'h0, bif0.mispredict}, 32'h0);
      chk("mrst.exception", {31'h0, bif0.exception}, 32'h0);
      chk("mrst.ras_top", bif0.ras_top, 32'h0);
      chk("mrst.ras_valid", {31'h0, bif0.ras_valid}, 32'h0);

      // Randomized traffic against the reference model
      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 6))
            0:       r.opcode = OP_LUI;
            1:       r.opcode = OP_AUIPC;
            2:       r.opcode = OP_JAL;
            3, 4:    r.opcode = OP_JALR;
            5:       r.opcode = OP_BR;
            default: r.opcode = OP_LOAD;
         endcase
         r.funct3 = 3'($urandom);
         if (r.opcode == OP_JALR && $urandom_range(0, 7) != 0) r.funct3 = 3'd0;
         r.rd     = pick_reg();
         r.rs1    = pick_reg();
         r.rvc    = 1'($urandom);
         r.src1   = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         r.src2   = ($urandom_range(0, 3) == 0) ? r.src1 : $urandom;
         r.imm    = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         r.old_pc = $urandom & 32'hFFFF_FFFC;
         r.pred_pc = 32'h0;
         e = ref_out(r, 1'b0);
         r.pred_pc = ($urandom_range(0, 1) == 0) ? e.new_pc : $urandom;
         e = ref_out(r, 1'b0);
         send0(r);
         chk_out($sformatf("rnd%0d", k), e);
         chk_ras($sformatf("rnd%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised, registered successor to the combinational flow-control decoder in the processor execute stage. It resolves LUI/AUIPC/JAL/JALR/Bxx for an XLEN-wide core, with optional RVC (16-bit) alignment and link rules. It adds a valid/ready pipeline register and a return-address stack (RAS) that drives fetch-side return prediction. It also flags mispredictions against the PC that fetch predicted.

## Interface
- XLEN, 32, datapath width (≥32)
- RAS_DEPTH, 8, RAS entries, power of two ≥2
- C_EXT, 0, 1 = RVC enabled: 2-byte target alignment, `rvc` honoured
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  drop registered result, block acceptance this cycle
- in_valid  in  1  request valid
- in_ready  out  1  = !flush && (!out_valid || out_ready)
- opcode  in  7; funct3  in  3; rd  in  5; rs1  in  5
- rvc  in  1  instruction is 16-bit (ignored when C_EXT=0)
- src1, src2, imm, old_pc, pred_pc  in  XLEN  operands, sign-extended imm, instruction PC, fetch-predicted next PC
- out_valid  out  1; out_ready  in  1
- dst  out  XLEN; dst_we  out  1  rd write value/enable
- new_pc  out  XLEN; taken  out  1; mispredict  out  1; exception  out  1
- ras_top  out  XLEN; ras_valid  out  1  return prediction for fetch

## Operation
- Accept = in_valid && in_ready. Decoded result is registered on the accepting edge, and out_valid is set.
- seq = old_pc + ((C_EXT && rvc) ? 2 : 4), computed modulo 2^XLEN. All adds wrap.
- LUI: dst=imm, dst_we=1, new_pc=seq.
- AUIPC: dst=old_pc+imm, dst_we=1, new_pc=seq.
- JAL: dst=seq, dst_we=1, taken=1, target=old_pc+imm.
- JALR (funct3=000): dst=seq, dst_we=1, taken=1, target=(src1+imm) & ~1.
- Bxx: compare src1 and src2.
  - funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - taken → new_pc=old_pc+imm; otherwise new_pc=seq. dst_we=0.
- Exception conditions:
  - Bxx with funct3 010/011.
  - JALR with funct3≠000.
  - Taken target misaligned: target[1:0]≠0 when C_EXT=0; target[0]≠0 when C_EXT=1. A not-taken branch is never checked.
- On exception: new_pc=old_pc, dst_we=0, taken=0, mispredict=0, no RAS update.
- Any other opcode: new_pc=seq, dst=0, dst_we=0, no exception.
- mispredict = !exception && (new_pc ≠ pred_pc).
- RAS link registers are x1 and x5 (L(r) = r∈{1,5}). Updates are applied on accept and only when there is no exception.
  - JAL, L(rd): push seq.
  - JALR, L(rd) && !L(rs1): push.
  - JALR, !L(rd) && L(rs1): pop.
  - JALR, L(rd) && L(rs1) && rd≠rs1: pop then push, i.e. replace top with seq; count unchanged.
  - JALR, L(rd) && rd==rs1: push.
  - Otherwise: no change.
- RAS structure: circular array, write pointer ptr (log2 RAS_DEPTH bits), count 0..RAS_DEPTH.
  - Push on full overwrites the oldest entry; ptr wraps; count saturates.
  - Pop on empty: no change.
- ras_top = entry[ptr-1], ras_valid = (count≠0). Both come from state, so an update is visible the cycle after accept.

## Timing
- Latency 1: an input accepted at edge N is presented with out_valid=1 after edge N.
- Back-to-back throughput of 1 per cycle while out_ready=1.
- While out_valid && !out_ready:
  - all out_* fields hold stable;
  - in_ready=0;
  - RAS holds.
- Output handshake completes on out_valid && out_ready. If accept occurs in the same cycle, out_valid stays 1 with the new data.
- flush: out_valid=0 next cycle; in_ready=0 this cycle; RAS retains all earlier updates.
- reset, which has priority over everything, clears on the next edge:
  - out_valid, dst, dst_we, new_pc, taken, mispredict, exception → 0;
  - RAS ptr, count and entries → 0, so ras_top=0 and ras_valid=0.
  - In-flight results are discarded.

## Test plan
- BEQ, old_pc=0x100, imm=0x20, src1=src2=5, pred_pc=0x104 → next cycle out_valid=1, new_pc=0x120, taken=1, mispredict=1, dst_we=0. Repeat with src2=6 → new_pc=0x104, mispredict=0.
- Call/return:
  - JAL rd=1, old_pc=0x200, imm=0x40 → dst=0x204, new_pc=0x240, ras_top=0x204, ras_valid=1.
  - Then JALR rd=0, rs1=1, src1=0x204, imm=0 → new_pc=0x204, ras_valid=0.
  - Then JALR rd=1, rs1=5 on a 1-deep stack → top replaced, count=1.
- RAS_DEPTH=8 overflow: 9 JAL rd=1 with old_pc=0x1000+0x10·k (k=0..8) → ras_top=0x1084. 8 pops return 0x1084…0x1014. The 9th pop leaves ras_valid=0 unchanged.
- Alignment:
  - C_EXT=0, JAL imm=0x2 → exception=1, new_pc=old_pc, ras unchanged.
  - C_EXT=1, same instruction with rvc=1, rd=1 → no exception, dst=old_pc+2.
  - Bxx funct3=010 → exception=1.
- Handshake:
  - out_ready=0 for 3 cycles → in_ready=0, outputs stable.
  - Simultaneous consume+accept → out_valid stays 1 with new data.
  - flush → out_valid=0.
  - reset asserted mid-stream → all outputs and RAS zero after one edge.
